// File: rtl/exe_muldiv_stage.sv
// EXE stage with a single-cycle ALU and a 32-iteration shift-add multiplier.
// Multiplies hold the pipeline through stall; the ALU path has 1-cycle latency.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting instructions; ALU ops complete in one edge
// MUL   | iterating shift-add; cnt counts completed iterations 0..31
module exe_muldiv_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        wreg,
  input  logic        m2reg,
  input  logic        wmem,
  input  logic        aluimm,
  input  logic        mul,
  input  logic [1:0]  aluOp,
  input  logic [4:0]  dest,
  input  logic [31:0] qa,
  input  logic [31:0] qb,
  input  logic [31:0] imm,
  output logic        stall,
  output logic        evalid,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic [4:0]  edest,
  output logic [31:0] ealu,
  output logic [31:0] eqb
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [31:0] mplier, mplier_nxt;
  logic [31:0] acc, acc_nxt;

  // instruction fields captured at multiply start, replayed with the product
  logic [4:0]  l_dest, l_dest_nxt;
  logic [31:0] l_qb, l_qb_nxt;
  logic        l_wreg, l_wreg_nxt;
  logic        l_m2reg, l_m2reg_nxt;
  logic        l_wmem, l_wmem_nxt;

  logic        evalid_nxt, ewreg_nxt, em2reg_nxt, ewmem_nxt;
  logic [4:0]  edest_nxt;
  logic [31:0] ealu_nxt, eqb_nxt;

  logic [31:0] opb;
  logic [31:0] alu_res;
  logic [31:0] acc_add;
  logic        stall_raw;

  // operand B mux and ALU
  always_comb begin
    opb = aluimm ? imm : qb;
    unique case (aluOp)
      2'b00:   alu_res = qa + opb;
      2'b01:   alu_res = qa - opb;
      2'b10:   alu_res = qa & opb;
      default: alu_res = qa | opb;
    endcase
  end

  // one shift-add iteration; the add uses the current multiplier LSB
  always_comb begin
    acc_add = mplier[0] ? (acc + mcand) : acc;
  end

  // next-state, datapath and output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    acc_nxt     = acc;
    l_dest_nxt  = l_dest;
    l_qb_nxt    = l_qb;
    l_wreg_nxt  = l_wreg;
    l_m2reg_nxt = l_m2reg;
    l_wmem_nxt  = l_wmem;
    evalid_nxt  = 1'b0;
    ewreg_nxt   = 1'b0;
    em2reg_nxt  = 1'b0;
    ewmem_nxt   = 1'b0;
    edest_nxt   = edest;
    ealu_nxt    = ealu;
    eqb_nxt     = eqb;
    stall_raw   = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          if (mul) begin
            state_nxt   = MUL;
            cnt_nxt     = 5'd0;
            mcand_nxt   = qa;
            mplier_nxt  = opb;
            acc_nxt     = 32'd0;
            l_dest_nxt  = dest;
            l_qb_nxt    = qb;
            l_wreg_nxt  = wreg;
            l_m2reg_nxt = m2reg;
            l_wmem_nxt  = wmem;
            stall_raw   = 1'b1;
          end else begin
            evalid_nxt = 1'b1;
            ewreg_nxt  = wreg;
            em2reg_nxt = m2reg;
            ewmem_nxt  = wmem;
            edest_nxt  = dest;
            ealu_nxt   = alu_res;
            eqb_nxt    = qb;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
        end else begin
          acc_nxt    = acc_add;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + 5'd1;
          if (cnt == 5'd31) begin
            // last iteration: upstream sees stall low and advances on this edge
            state_nxt  = IDLE;
            evalid_nxt = 1'b1;
            ewreg_nxt  = l_wreg;
            em2reg_nxt = l_m2reg;
            ewmem_nxt  = l_wmem;
            edest_nxt  = l_dest;
            ealu_nxt   = acc_add;
            eqb_nxt    = l_qb;
          end else begin
            stall_raw = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  // reset holds stall low even though state is already IDLE
  assign stall = stall_raw & rst_n;

  // FSM state and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // multiplier datapath and latched instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      acc     <= 32'd0;
      l_dest  <= 5'd0;
      l_qb    <= 32'd0;
      l_wreg  <= 1'b0;
      l_m2reg <= 1'b0;
      l_wmem  <= 1'b0;
    end else begin
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      acc     <= acc_nxt;
      l_dest  <= l_dest_nxt;
      l_qb    <= l_qb_nxt;
      l_wreg  <= l_wreg_nxt;
      l_m2reg <= l_m2reg_nxt;
      l_wmem  <= l_wmem_nxt;
    end
  end

  // EXE/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evalid <= 1'b0;
      ewreg  <= 1'b0;
      em2reg <= 1'b0;
      ewmem  <= 1'b0;
      edest  <= 5'd0;
      ealu   <= 32'd0;
      eqb    <= 32'd0;
    end else begin
      evalid <= evalid_nxt;
      ewreg  <= ewreg_nxt;
      em2reg <= em2reg_nxt;
      ewmem  <= ewmem_nxt;
      edest  <= edest_nxt;
      ealu   <= ealu_nxt;
      eqb    <= eqb_nxt;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Directed bench for exe_muldiv_stage: stimulus pushes hand-computed results
// into a scoreboard, a negedge monitor pops and compares on every evalid.
module tb_exe_muldiv_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid, flush, wreg, m2reg, wmem, aluimm, mul;
  logic [1:0]  aluOp;
  logic [4:0]  dest;
  logic [31:0] qa, qb, imm;
  logic        stall, evalid, ewreg, em2reg, ewmem;
  logic [4:0]  edest;
  logic [31:0] ealu, eqb;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] qb;
    logic [4:0]  dest;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  exe_muldiv_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .mul(mul),
    .aluOp(aluOp), .dest(dest), .qa(qa), .qb(qb), .imm(imm),
    .stall(stall), .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .edest(edest), .ealu(ealu), .eqb(eqb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && evalid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got ealu=%h edest=%0d expected no result", ealu, edest);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {8'd0, ealu, eqb, edest, ewreg, em2reg, ewmem},
              {8'd0, e.alu, e.qb, e.dest, e.wreg, e.m2reg, e.wmem});
        check("latency", 80'(cyc), 80'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; mul = 0; wreg = 0; m2reg = 0; wmem = 0;
    aluimm = 0; aluOp = 2'b00; dest = 0; qa = 0; qb = 0; imm = 0;
  endtask

  task automatic issue_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic ai, input logic [4:0] d,
                           input logic w, input logic m2, input logic wm,
                           input logic [31:0] exp_alu);
    exp_t e;
    in_valid = 1; flush = 0; mul = 0; aluOp = op; qa = a; qb = b; imm = im;
    aluimm = ai; dest = d; wreg = w; m2reg = m2; wmem = wm;
    e.alu = exp_alu; e.qb = b; e.dest = d; e.wreg = w; e.m2reg = m2; e.wmem = wm;
    e.cyc = cyc + 1;
    sb.push_back(e);
    #1;
    check("alu_stall", 80'(stall), 80'(0));
    step();
  endtask

  task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic ai, input logic [4:0] d, input logic w,
                           input logic m2, input logic wm, input logic [31:0] exp_prod);
    exp_t e;
    int   k;
    int   start;
    in_valid = 1; flush = 0; mul = 1; aluOp = 2'b00; qa = a; qb = b; imm = im;
    aluimm = ai; dest = d; wreg = w; m2reg = m2; wmem = wm;
    start = cyc;
    k = 0;
    while (k < 40) begin
      #1;
      if (!stall) break;
      k++;
      step();
    end
    check("mul_stall_cycles", 80'(k), 80'(32));
    e.alu = exp_prod; e.qb = b; e.dest = d; e.wreg = w; e.m2reg = m2; e.wmem = wm;
    e.cyc = start + 33;
    sb.push_back(e);
    step();
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    in_valid = 1; mul = 1;
    #2;
    check("reset_outputs", {48'd0, evalid, ewreg, em2reg, ewmem, edest, ealu[22:0]}, 80'd0);
    check("reset_outputs_hi", {16'd0, ealu, eqb}, 80'd0);
    check("reset_stall", 80'(stall), 80'(0));
    set_idle();
    #10 rst_n = 1;
    step();

    // ALU path
    issue_alu(2'b01, 32'd5, 32'd3, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd2);
    issue_alu(2'b00, 32'hFFFF_FFFF, 32'h0000_1234, 32'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0);
    issue_alu(2'b10, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 32'h00F0_1200);
    issue_alu(2'b11, 32'h0000_00F0, 32'hDEAD_BEEF, 32'h0000_0F0F, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0FFF);
    issue_alu(2'b01, 32'd0, 32'd1, 32'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // bubbles hold the data fields
    issue_alu(2'b00, 32'd100, 32'd23, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'd123);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("bubble_evalid", 80'(evalid), 80'(0));
      check("bubble_hold", {43'd0, edest, ealu}, {43'd0, 5'd4, 32'd123});
    end

    // multiply, then the next instruction one cycle later
    issue_mul(32'h0001_0003, 32'h0002_0005, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h000B_000F);
    issue_alu(2'b00, 32'd1, 32'd1, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 32'd2);
    // wrapping product using the immediate as multiplier
    issue_mul(32'hFFFF_FFFF, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 32'd1);
    // back-to-back multiply with other controls
    issue_mul(32'd7, 32'd6, 32'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, 32'd42);
    set_idle();
    step();

    // flush in IDLE kills an ALU op
    in_valid = 1; flush = 1; aluOp = 2'b00; qa = 32'd9; qb = 32'd9; dest = 5'd20; wreg = 1;
    step();
    check("idle_flush_bubble", 80'(evalid), 80'(0));

    // flush during a multiply at cnt=10, with in_valid still asserted
    set_idle();
    in_valid = 1; mul = 1; qa = 32'd3; qb = 32'd4; dest = 5'd6; wreg = 1;
    for (int i = 0; i < 11; i++) step();
    check("stall_before_flush", 80'(stall), 80'(1));
    flush = 1;
    #1;
    check("flush_stall", 80'(stall), 80'(0));
    step();
    check("flush_bubble", 80'(evalid), 80'(0));
    set_idle();
    #1;
    check("flush_idle_stall", 80'(stall), 80'(0));
    issue_alu(2'b01, 32'd8, 32'd2, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd6);
    set_idle();
    for (int i = 0; i < 40; i++) step();

    // asynchronous reset mid-multiply
    in_valid = 1; mul = 1; qa = 32'd5; qb = 32'd5; dest = 5'd11; wreg = 1;
    for (int i = 0; i < 6; i++) step();
    #3;
    rst_n = 0;
    #1;
    check("async_reset_outputs", {5'd0, evalid, ewreg, em2reg, ewmem, edest, ealu[31:0], eqb[31:0]}, 80'd0);
    check("async_reset_stall", 80'(stall), 80'(0));
    set_idle();
    @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 40; i++) step();
    issue_alu(2'b00, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'd5);
    set_idle();
    step();
    step();

    check("scoreboard_drained", 80'(sb.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_stage.md
EXE_MULDIV_STAGE -- requirements
Module: exe_muldiv_stage

Interface
REQ-001 The block SHALL have these ports; clock and reset come first:
- clk  in  1  the only clock; everything updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the ID/EXE fields hold a real instruction.
- flush  in  1  synchronous kill of the current and in-flight operation.
- wreg, m2reg, wmem, aluimm, mul  in  1 each  decoded controls; mul selects the multiply path.
- aluOp  in  2  ALU operation code.
- dest  in  5  destination register number.
- qa, qb, imm  in  32 each  operand A, operand B, sign-extended immediate.
- stall  out  1  tells upstream to hold its fields; combinational.
- evalid, ewreg, em2reg, ewmem  out  1 each  registered EXE/MEM controls.
- edest  out  5  registered destination register.
- ealu, eqb  out  32 each  registered result and store data.

Function
REQ-002 Operand B (opB) SHALL be imm when aluimm=1, else qb.
REQ-003 ALU results SHALL be: aluOp 00 = qa+opB, 01 = qa-opB, 10 = qa&opB, 11 = qa|opB, modulo 2^32, with no overflow flag.
REQ-004 The FSM SHALL have two states, IDLE and MUL, plus a 5-bit iteration counter cnt.
REQ-005 In IDLE, when in_valid=1, mul=0 and flush=0, the next edge SHALL register the ALU result into ealu, qb into eqb, dest into edest, the controls into ewreg/em2reg/ewmem, and set evalid=1 (1-cycle latency).
REQ-006 In IDLE, when in_valid=0 or flush=1, the next edge SHALL write a bubble: evalid=ewreg=em2reg=ewmem=0, while ealu, eqb and edest hold their values.
REQ-007 In IDLE, when in_valid=1, mul=1 and flush=0, the next edge SHALL do all of the following, and the outputs SHALL take a bubble:
- go to MUL with cnt=0;
- load mcand=qa, mplier=opB, acc=0;
- latch dest, qb, wreg, m2reg and wmem.
REQ-008 Each MUL edge SHALL do the following: if mplier[0]=1 then acc+=mcand; then mcand<<=1, mplier>>=1, cnt+=1. Arithmetic is 32-bit, keeping only the low 32 bits of the product.
REQ-009 While cnt<31, each MUL edge SHALL write a bubble to the outputs.
REQ-010 The MUL edge with cnt=31 SHALL:
- write the final acc into ealu;
- write the latched dest, qb and controls to the outputs;
- set evalid=1;
- return the FSM to IDLE.
REQ-011 stall SHALL equal the following, and SHALL be forced to 0 whenever flush=1:
- 1 in IDLE when in_valid & mul;
- 1 in MUL when cnt!=31;
- 0 otherwise.
REQ-012 Upstream SHALL present the same multiply instruction for every cycle stall=1. The block SHALL ignore the input fields while in MUL.
REQ-013 Because stall drops in the cnt=31 cycle, upstream advances on the same edge that the multiply result is registered. The same multiply SHALL NOT restart.
REQ-014 A multiply SHALL take 33 edges from first presentation to evalid=1, with stall high for exactly 32 cycles.
REQ-015 flush=1 in MUL SHALL abort the multiply: on the next edge the FSM goes to IDLE and the outputs take a bubble. flush SHALL take priority over in_valid arriving in the same cycle.
REQ-016 A product that overflows 32 bits SHALL wrap, with no error indication.

Reset
REQ-017 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, do all of the following:
- set the FSM to IDLE and cnt=0;
- clear acc, mcand and mplier;
- drive evalid, ewreg, em2reg, ewmem, edest, ealu and eqb to 0.
REQ-018 stall SHALL be 0 during reset.
REQ-019 A reset asserted during MUL SHALL discard the multiply, and SHALL produce no result after rst_n is released.
REQ-020 After rst_n rises, the first rising edge SHALL be treated as an ordinary IDLE edge.

Verification
REQ-021 ALU path:
- Stimulus: qa=5, qb=3, aluOp=01, aluimm=0, dest=7, wreg=1.
- Response: next edge gives ealu=2, edest=7, ewreg=1, evalid=1, with stall=0 throughout.
REQ-022 Immediate and wrap:
- Stimulus: qa=0xFFFFFFFF, imm=1, aluimm=1, aluOp=00.
- Response: ealu=0.
REQ-023 Multiply:
- Stimulus: qa=0x00010003, qb=0x00020005, mul=1, dest=9, held while stall=1.
- Response: stall high for 32 cycles, evalid=1 on edge 33 with ealu=0x000B000F and edest=9; the following instruction then completes 1 cycle later.
REQ-024 Flush during a multiply:
- Stimulus: flush=1 at cnt=10.
- Response: stall=0 that cycle, outputs are a bubble on the next edge, the FSM is in IDLE, and no result appears for the aborted multiply.
REQ-025 Asynchronous reset during a multiply:
- Stimulus: rst_n=0 mid-MUL, applied between clock edges.
- Response: all outputs go to 0 immediately, with no result after release.
REQ-026 Bubbles:
- Stimulus: in_valid=0 for 3 cycles after a valid ADD.
- Response: evalid=0 each cycle while ealu holds the ADD value.
